add_sum_accum: RTL and testbench
================================

Name: add_sum_accum

Overview:
- Downstream consumer of the 2-stage pipelined 15-bit adder.
- Tracks which adder outputs are valid by delaying the operand-issue strobe by the adder latency.
- Accumulates COUNT consecutive valid sums into one block result, flags arithmetic overflow, and presents the result on a valid/ready output port with overrun detection.
- The adder cannot stall, so this block never back-pressures it.

Parameters:
- WIDTH, 15, width of the adder sum input.
- LAT, 2, adder latency in cycles from operand issue to sum valid; legal range >= 1.
- COUNT, 4, sums per block; legal range >= 2.
- ACC_WIDTH, 16, accumulator and result width; legal range >= WIDTH. Results wrap modulo 2^ACC_WIDTH.

Ports:
- clk  in  1  rising-edge clock, shared with the adder.
- rst  in  1  synchronous active-high reset.
- op_valid  in  1  operands presented to the adder this cycle.
- sum  in  WIDTH  adder sum output, unsigned.
- flush  in  1  synchronous; discards the partial block and all in-flight valids.
- out_ready  in  1  downstream accepts the result.
- out_valid  out  1  block result available.
- out_acc  out  ACC_WIDTH  block result.
- out_ovf  out  1  a carry out of ACC_WIDTH occurred within this block.
- overrun  out  1  sticky; a completed block was dropped because the output was full.
- busy  out  1  partial block in progress or any valid in flight.

Behaviour:
- Clock and reset: a single clock, clk. rst is synchronous and active-high.
- Reset values:
  - vpipe, cnt, acc, acc_ovf, out_valid, out_acc, out_ovf and overrun are all 0.
  - rst has priority over every other input.
- Valid alignment:
  - vpipe is a LAT-bit shift register; vpipe[0] <= op_valid.
  - sum_valid = vpipe[LAT-1].
  - sum is only sampled when sum_valid=1.
- Accumulate FSM (state is cnt, 0..COUNT-1; IDLE when cnt=0, RUN when cnt>0):
  - Transitions happen only when sum_valid=1. With sum_valid=0, all state holds.
  - IDLE: acc <= zero-extended sum, acc_ovf <= 0, cnt <= 1.
  - RUN with cnt < COUNT-1: {c, acc} <= acc + sum; acc_ovf <= acc_ovf | c; cnt++.
  - RUN with cnt = COUNT-1: completion. Result is acc+sum mod 2^ACC_WIDTH; ovf is acc_ovf | carry. Then cnt <= 0, acc <= 0, acc_ovf <= 0.
  - Latency: the final sum is sampled in cycle t; out_valid=1 from cycle t+1.
- Output register (EMPTY when out_valid=0, FULL when out_valid=1):
  - Accept: a transfer occurs when out_valid & out_ready.
  - Completion while EMPTY, or while FULL with out_ready=1 in the same cycle: load out_acc and out_ovf; out_valid <= 1.
  - Completion while FULL with out_ready=0: the new result is dropped. out_acc and out_ovf hold, and overrun <= 1.
  - Accept with no completion: out_valid <= 0. out_acc holds its last value.
  - out_acc and out_ovf are stable while out_valid=1 and out_ready=0.
- flush:
  - Clears vpipe, cnt, acc and acc_ovf in that cycle.
  - Does not affect the output register or overrun.
  - A sum_valid in the flush cycle is discarded.
  - An op_valid in the flush cycle is discarded too; vpipe[0] <= 0.
- overrun clears only on rst.
- busy = (cnt != 0) | (|vpipe).

Decomposition:
- Shared package add_pkg holds:
  - ADD_WIDTH=15 and ADD_LAT=2, which are the adder's width and latency.
  - ACC_IDLE/ACC_RUN state encoding constants.
- Sub-module add_valid_pipe (parameter LAT; ports clk, rst, clr, in, out) implements vpipe.
- The accumulator and output register stay in add_sum_accum.

Test Plan:
All scenarios use the defaults.
- Basic block: op_valid on 4 consecutive cycles with sums 100, 200, 300, 400 arriving 2 cycles later, out_ready=1 -> out_valid pulses 1 cycle after the 4th sum; out_acc=1000, out_ovf=0, busy then 0.
- Overflow: four sums of 0x7FFF -> out_acc=0xFFFC, out_ovf=1. The next block of 1, 1, 1, 1 -> out_acc=4, out_ovf=0.
- Backpressure and overrun:
  - Setup: out_ready=0; first block of 1, 2, 3, 4 gives out_acc=10; a second block of 5, 5, 5, 5 completes.
  - Response: out_acc stays 10 and overrun=1.
  - Then out_ready=1 -> transfer of 10; overrun stays 1 until rst.
- Simultaneous accept and completion: out_valid=1 holding 10 with out_ready=1 in the cycle block 2 (sum 20) completes -> the next cycle has out_valid=1, out_acc=20, overrun=0.
- Sparse valids: the 4 sums arrive with gaps of 0, 3 and 1 idle cycles (op_valid low between) -> the same result as back-to-back; sum is ignored when sum_valid=0, so drive garbage there.
- rst/flush mid-block:
  - Two sums (7, 9), then rst (or flush) with one op_valid in flight.
  - Then a fresh block of 1, 1, 1, 1 -> out_acc=4.
  - The in-flight sum is ignored.
  - flush leaves a pending out_valid and overrun untouched.

Source files
------------

// File: rtl/add_pkg.sv
// Shared definitions for the adder and its downstream sum accumulator.
//   ADD_WIDTH   : width of the adder sum output
//   ADD_LAT     : adder latency, operand issue to sum valid (cycles)
//   acc_state_e : accumulator state encoding (IDLE when the count is 0)
package add_pkg;

   localparam int ADD_WIDTH = 15;
   localparam int ADD_LAT   = 2;

   typedef enum logic {
      ACC_IDLE = 1'b0,
      ACC_RUN  = 1'b1
   } acc_state_e;

endpackage

// File: rtl/add_valid_pipe.sv
// Delays the operand-issue strobe by the adder latency so the strobe lines
// up with the sum it belongs to.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   clr : synchronous clear of every in-flight strobe (input also dropped)
//   in  : operand-issue strobe
//   out : whole delay line; out[LAT-1] marks a valid sum, out[0] is newest
module add_valid_pipe #(
   parameter int LAT = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   input  logic           in,
   output logic [LAT-1:0] out
);

   logic [LAT-1:0] vpipe_q;
   logic [LAT-1:0] vpipe_d;

   generate
      if (LAT == 1) begin : g_single
         assign vpipe_d = in;
      end else begin : g_shift
         assign vpipe_d = {vpipe_q[LAT-2:0], in};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         vpipe_q <= '0;
      end else begin
         vpipe_q <= vpipe_d;
      end
   end

   assign out = vpipe_q;

endmodule

// File: rtl/add_sum_accum.sv
// Accumulates COUNT consecutive valid adder sums into one block result,
// tracks carries out of the accumulator, and presents the result on a
// valid/ready port.  A result completing while the port is still full is
// dropped and recorded in the sticky overrun flag; the adder is never stalled.
//   clk, rst   : clock, synchronous active-high reset
//   op_valid   : operands issued to the adder this cycle
//   sum        : adder sum, sampled only when its delayed strobe is set
//   flush      : drop the partial block and every in-flight strobe
//   out_ready  : downstream accepts the result
//   out_valid  : block result available
//   out_acc    : block result (mod 2^ACC_WIDTH)
//   out_ovf    : a carry out of ACC_WIDTH occurred within the block
//   overrun    : sticky, a completed block was dropped
//   busy       : partial block in progress or a strobe in flight
module add_sum_accum
   import add_pkg::*;
#(
   parameter int WIDTH     = ADD_WIDTH,
   parameter int LAT       = ADD_LAT,
   parameter int COUNT     = 4,
   parameter int ACC_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 op_valid,
   input  logic [WIDTH-1:0]     sum,
   input  logic                 flush,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [ACC_WIDTH-1:0] out_acc,
   output logic                 out_ovf,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CNT_W = $clog2(COUNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

   // Returns {carry, a + b} so the carry out of the accumulator is explicit.
   function automatic logic [ACC_WIDTH:0] acc_add(input logic [ACC_WIDTH-1:0] a,
                                                  input logic [ACC_WIDTH-1:0] b);
      acc_add = {1'b0, a} + {1'b0, b};
   endfunction

   logic [LAT-1:0]       vpipe;
   logic                 sum_valid;

   logic [CNT_W-1:0]     cnt_q,       cnt_d;
   logic [ACC_WIDTH-1:0] acc_q,       acc_d;
   logic                 acc_ovf_q,   acc_ovf_d;
   logic                 out_valid_q, out_valid_d;
   logic [ACC_WIDTH-1:0] out_acc_q,   out_acc_d;
   logic                 out_ovf_q,   out_ovf_d;
   logic                 overrun_q,   overrun_d;

   acc_state_e           state;
   logic [ACC_WIDTH-1:0] sum_ext;
   logic [ACC_WIDTH:0]   add_res;
   logic                 done;

   add_valid_pipe #(.LAT(LAT)) u_vpipe (
      .clk (clk),
      .rst (rst),
      .clr (flush),
      .in  (op_valid),
      .out (vpipe)
   );

   assign sum_valid = vpipe[LAT-1];
   assign state     = (cnt_q == '0) ? ACC_IDLE : ACC_RUN;
   assign sum_ext   = ACC_WIDTH'(sum);
   assign add_res   = acc_add(acc_q, sum_ext);

   // Accumulator: advances only on a valid sum; flush discards the block.
   always_comb begin
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      acc_ovf_d = acc_ovf_q;
      done      = 1'b0;
      if (flush) begin
         cnt_d     = '0;
         acc_d     = '0;
         acc_ovf_d = 1'b0;
      end else if (sum_valid) begin
         case (state)
            ACC_IDLE: begin
               acc_d     = sum_ext;
               acc_ovf_d = 1'b0;
               cnt_d     = CNT_W'(1);
            end
            default: begin
               if (cnt_q == CNT_LAST) begin
                  done      = 1'b1;
                  cnt_d     = '0;
                  acc_d     = '0;
                  acc_ovf_d = 1'b0;
               end else begin
                  acc_d     = add_res[ACC_WIDTH-1:0];
                  acc_ovf_d = acc_ovf_q | add_res[ACC_WIDTH];
                  cnt_d     = cnt_q + CNT_W'(1);
               end
            end
         endcase
      end
   end

   // Output register: a completion may reuse the slot being accepted this
   // cycle; otherwise a completion into a full slot is dropped.
   always_comb begin
      out_valid_d = out_valid_q;
      out_acc_d   = out_acc_q;
      out_ovf_d   = out_ovf_q;
      overrun_d   = overrun_q;
      if (done) begin
         if (!out_valid_q || out_ready) begin
            out_valid_d = 1'b1;
            out_acc_d   = add_res[ACC_WIDTH-1:0];
            out_ovf_d   = acc_ovf_q | add_res[ACC_WIDTH];
         end else begin
            overrun_d   = 1'b1;
         end
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         acc_q       <= '0;
         acc_ovf_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_acc_q   <= '0;
         out_ovf_q   <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         acc_ovf_q   <= acc_ovf_d;
         out_valid_q <= out_valid_d;
         out_acc_q   <= out_acc_d;
         out_ovf_q   <= out_ovf_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_acc   = out_acc_q;
   assign out_ovf   = out_ovf_q;
   assign overrun   = overrun_q;
   assign busy      = (cnt_q != '0) | (|vpipe);

endmodule

// File: tb/tb_add_sum_accum.sv
module tb_add_sum_accum;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        op_valid = 1'b0;
   logic [14:0] sum = '0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b1;
   logic        out_valid;
   logic [15:0] out_acc;
   logic        out_ovf;
   logic        overrun;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // expected block results {ovf, acc}
   logic [16:0] exp_q[$];

   // behavioural 2-cycle adder: sum issued with op_valid appears 2 cycles later
   logic [14:0] adp_s[2];
   logic        adp_v[2];

   add_sum_accum dut (
      .clk       (clk),
      .rst       (rst),
      .op_valid  (op_valid),
      .sum       (sum),
      .flush     (flush),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_acc   (out_acc),
      .out_ovf   (out_ovf),
      .overrun   (overrun),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // scoreboard: every transfer pops the oldest expected result
   always @(negedge clk) begin
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL transfer_unexpected: got acc=%0d ovf=%0b, expected no transfer", out_acc, out_ovf);
         end else begin
            logic [16:0] e;
            e = exp_q.pop_front();
            if ({out_ovf, out_acc} !== e) begin
               errors++;
               $display("FAIL transfer_value: got acc=%0d ovf=%0b, expected acc=%0d ovf=%0b",
                        out_acc, out_ovf, e[15:0], e[16]);
            end
         end
      end
   end

   function automatic logic [16:0] blk(input logic [14:0] a, input logic [14:0] b,
                                       input logic [14:0] c, input logic [14:0] d);
      logic [15:0] acc;
      logic [16:0] t;
      logic        o;
      acc = {1'b0, a};
      o   = 1'b0;
      t = {1'b0, acc} + {2'b0, b}; o = o | t[16]; acc = t[15:0];
      t = {1'b0, acc} + {2'b0, c}; o = o | t[16]; acc = t[15:0];
      t = {1'b0, acc} + {2'b0, d}; o = o | t[16]; acc = t[15:0];
      return {o, acc};
   endfunction

   task automatic tick(input logic opv, input logic [14:0] s);
      op_valid = opv;
      sum = adp_v[1] ? adp_s[1] : 15'($urandom);
      @(posedge clk);
      #1;
      adp_s[1] = adp_s[0];
      adp_v[1] = adp_v[0];
      adp_s[0] = s;
      adp_v[0] = opv;
      op_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick(1'b0, 15'd0);
      rst = 1'b0;
      adp_v[0] = 1'b0;
      adp_v[1] = 1'b0;
   endtask

   task automatic run_block(input logic [14:0] a, input logic [14:0] b,
                            input logic [14:0] c, input logic [14:0] d,
                            input bit push);
      if (push) exp_q.push_back(blk(a, b, c, d));
      tick(1'b1, a);
      tick(1'b1, b);
      tick(1'b1, c);
      tick(1'b1, d);
      for (int i = 0; i < 4; i++) tick(1'b0, 15'd0);
   endtask

   task automatic test_reset();
      adp_v[0] = 1'b0;
      adp_v[1] = 1'b0;
      rst = 1'b1;
      tick(1'b1, 15'd3);
      tick(1'b1, 15'd3);
      rst = 1'b0;
      adp_v[0] = 1'b0;
      adp_v[1] = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (out_acc !== 16'd0) begin errors++; $display("FAIL reset_out_acc: got %0d expected 0", out_acc); end
      checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %b expected 0", out_ovf); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
   endtask

   task automatic test_basic();
      exp_q.push_back(blk(15'd100, 15'd200, 15'd300, 15'd400));
      tick(1'b1, 15'd100);
      tick(1'b1, 15'd200);
      tick(1'b1, 15'd300);
      tick(1'b1, 15'd400);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_mid: got %b expected 1", busy); end
      tick(1'b0, 15'd0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
      tick(1'b0, 15'd0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
      checks++; if (out_acc !== 16'd1000) begin errors++; $display("FAIL basic_acc: got %0d expected 1000", out_acc); end
      checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", out_ovf); end
      tick(1'b0, 15'd0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b expected 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
   endtask

   task automatic test_overflow();
      run_block(15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF, 1'b1);
      checks++; if ({out_ovf, out_acc} !== 17'h1FFFC) begin errors++; $display("FAIL ovf_hold: got acc=%h ovf=%b expected acc=fffc ovf=1", out_acc, out_ovf); end
      run_block(15'd1, 15'd1, 15'd1, 15'd1, 1'b1);
      checks++; if ({out_ovf, out_acc} !== 17'd4) begin errors++; $display("FAIL ovf_next: got acc=%0d ovf=%b expected acc=4 ovf=0", out_acc, out_ovf); end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      exp_q.push_back(blk(15'd1, 15'd2, 15'd3, 15'd4));
      tick(1'b1, 15'd1);
      tick(1'b1, 15'd2);
      tick(1'b1, 15'd3);
      tick(1'b1, 15'd4);
      run_block(15'd5, 15'd5, 15'd5, 15'd5, 1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", out_valid); end
      checks++; if (out_acc !== 16'd10) begin errors++; $display("FAIL bp_acc_hold: got %0d expected 10", out_acc); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun: got %b expected 1", overrun); end
      out_ready = 1'b1;
      tick(1'b0, 15'd0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
      tick(1'b0, 15'd0);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_sticky: got %b expected 1", overrun); end
   endtask

   task automatic test_simultaneous();
      do_reset();
      out_ready = 1'b0;
      exp_q.push_back(blk(15'd1, 15'd2, 15'd3, 15'd4));
      exp_q.push_back(blk(15'd5, 15'd5, 15'd5, 15'd5));
      run_block(15'd1, 15'd2, 15'd3, 15'd4, 1'b0);
      tick(1'b1, 15'd5);
      tick(1'b1, 15'd5);
      tick(1'b1, 15'd5);
      tick(1'b1, 15'd5);
      tick(1'b0, 15'd0);
      out_ready = 1'b1;
      tick(1'b0, 15'd0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL simul_valid: got %b expected 1", out_valid); end
      checks++; if (out_acc !== 16'd20) begin errors++; $display("FAIL simul_acc: got %0d expected 20", out_acc); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL simul_overrun: got %b expected 0", overrun); end
      tick(1'b0, 15'd0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL simul_drain: got %b expected 0", out_valid); end
   endtask

   task automatic test_sparse();
      exp_q.push_back(blk(15'd100, 15'd200, 15'd300, 15'd400));
      tick(1'b1, 15'd100);
      tick(1'b1, 15'd200);
      for (int i = 0; i < 3; i++) tick(1'b0, 15'd0);
      tick(1'b1, 15'd300);
      tick(1'b0, 15'd0);
      tick(1'b1, 15'd400);
      for (int i = 0; i < 4; i++) tick(1'b0, 15'd0);
      checks++; if (out_acc !== 16'd1000) begin errors++; $display("FAIL sparse_acc: got %0d expected 1000", out_acc); end
   endtask

   task automatic test_rst_mid();
      do_reset();
      tick(1'b1, 15'd7);
      tick(1'b1, 15'd9);
      tick(1'b0, 15'd0);
      tick(1'b1, 15'd55);
      rst = 1'b1;
      tick(1'b0, 15'd0);
      rst = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      run_block(15'd1, 15'd1, 15'd1, 15'd1, 1'b1);
      checks++; if (out_acc !== 16'd4) begin errors++; $display("FAIL rstmid_acc: got %0d expected 4", out_acc); end
   endtask

   task automatic test_flush_mid();
      do_reset();
      out_ready = 1'b0;
      exp_q.push_back(blk(15'd1, 15'd2, 15'd3, 15'd4));
      tick(1'b1, 15'd1);
      tick(1'b1, 15'd2);
      tick(1'b1, 15'd3);
      tick(1'b1, 15'd4);
      run_block(15'd5, 15'd5, 15'd5, 15'd5, 1'b0);
      tick(1'b1, 15'd7);
      tick(1'b1, 15'd9);
      tick(1'b0, 15'd0);
      tick(1'b1, 15'd55);
      flush = 1'b1;
      tick(1'b0, 15'd0);
      flush = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", busy); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_valid: got %b expected 1", out_valid); end
      checks++; if (out_acc !== 16'd10) begin errors++; $display("FAIL flush_acc_hold: got %0d expected 10", out_acc); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL flush_overrun: got %b expected 1", overrun); end
      out_ready = 1'b1;
      tick(1'b0, 15'd0);
      run_block(15'd1, 15'd1, 15'd1, 15'd1, 1'b1);
      checks++; if (out_acc !== 16'd4) begin errors++; $display("FAIL flush_next_acc: got %0d expected 4", out_acc); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL flush_sticky: got %b expected 1", overrun); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_backpressure();
      test_simultaneous();
      test_sparse();
      test_rst_mid();
      test_flush_mid();
      tick(1'b0, 15'd0);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending results, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
